unidade_busca: RTL

Instruction-fetch sequencer for the 8-bit N-RISC processor. Holds the program counter, runs a request/acknowledge read against instruction memory, and presents each fetched instruction to decode over a valid/ready handshake. Sits directly upstream of the two-input next-PC selector: it drives the selector's `entrada1` with `pc_incrementado` and loads the selector's `saida` back as the next PC.

---
 rtl/nrisc_pkg.sv | 15 +
 rtl/unidade_busca_registrador_pc.sv | 24 ++
 rtl/unidade_busca.sv | 108 ++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared N-RISC definitions: fetch FSM states, default widths and reset PC.
package nrisc_pkg;

    localparam int               LARGURA_PC_PADRAO    = 8;
    localparam int               LARGURA_INSTR_PADRAO = 8;
    localparam int               LARGURA_BUSCAS       = 16;
    localparam int unsigned      PC_INICIAL_PADRAO    = 0;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_busca_registrador_pc.sv
// Program-counter register: async active-low reset, load enable and a
// combinational +1 output that wraps modulo 2^LARGURA.
module registrador_pc #(
    parameter int                 LARGURA     = 8,
    parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               carrega,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q,
    output logic [LARGURA-1:0] q_mais_um
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            q <= VALOR_RESET;
        else if (carrega)
            q <= d;
    end

    assign q_mais_um = q + LARGURA'(1);

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch sequencer: req/ack memory read, valid/ready delivery to decode.
// Optional 16-bit saturating fetch counter on port buscas: UNIDADE_BUSCA_CONTADOR_BUSCAS_EN.
module unidade_busca
    import nrisc_pkg::*;
#(
    parameter int          LARGURA_PC    = LARGURA_PC_PADRAO,
    parameter int          LARGURA_INSTR = LARGURA_INSTR_PADRAO,
    parameter int unsigned PC_INICIAL    = PC_INICIAL_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     habilita,
    output logic                     mem_req,
    output logic [LARGURA_PC-1:0]    mem_endereco,
    input  logic                     mem_ack,
    input  logic [LARGURA_INSTR-1:0] mem_dado,
    output logic [LARGURA_INSTR-1:0] instrucao,
    output logic                     instr_valido,
    input  logic                     instr_pronto,
    output logic [LARGURA_PC-1:0]    pc,
    output logic [LARGURA_PC-1:0]    pc_incrementado,
    input  logic [LARGURA_PC-1:0]    proximo_pc
`ifdef UNIDADE_BUSCA_CONTADOR_BUSCAS_EN
    ,
    output logic [LARGURA_BUSCAS-1:0] buscas
`endif
);

    localparam logic [LARGURA_PC-1:0] PC_RESET = LARGURA_PC'(PC_INICIAL);

    estado_t estado, proximo_estado;
    logic    captura;
    logic    entrega;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            estado <= OCIOSO;
        else
            estado <= proximo_estado;
    end

    // habilita is only sampled at the two exits, so a fetch in flight
    // always completes its delivery before the unit parks.
    always_comb begin
        proximo_estado = estado;
        captura        = 1'b0;
        entrega        = 1'b0;
        case (estado)
            OCIOSO: begin
                if (habilita)
                    proximo_estado = BUSCA;
            end
            BUSCA: begin
                if (mem_ack) begin
                    captura        = 1'b1;
                    proximo_estado = ENTREGA;
                end
            end
            ENTREGA: begin
                if (instr_pronto) begin
                    entrega        = 1'b1;
                    proximo_estado = habilita ? BUSCA : OCIOSO;
                end
            end
            default: proximo_estado = OCIOSO;
        endcase
    end

    // Pure decodes of the state register: they follow reset asynchronously
    // and are mutually exclusive by construction.
    assign mem_req      = (estado == BUSCA);
    assign instr_valido = (estado == ENTREGA);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            instrucao <= '0;
        else if (captura)
            instrucao <= mem_dado;
    end

    registrador_pc #(
        .LARGURA     (LARGURA_PC),
        .VALOR_RESET (PC_RESET)
    ) u_registrador_pc (
        .clock     (clock),
        .reset_n   (reset_n),
        .carrega   (entrega),
        .d         (proximo_pc),
        .q         (pc),
        .q_mais_um (pc_incrementado)
    );

    assign mem_endereco = pc;

`ifdef UNIDADE_BUSCA_CONTADOR_BUSCAS_EN
    logic [LARGURA_BUSCAS-1:0] contador;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            contador <= '0;
        else if (entrega && (contador != {LARGURA_BUSCAS{1'b1}}))
            contador <= contador + LARGURA_BUSCAS'(1);
    end

    assign buscas = contador;
`endif

endmodule
